// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between ALU writeback and the mult/div unit.
// A colliding md result waits in a one-entry buffer; if it waits too long, the ALU is stalled.
module wb_port_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_we,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              stall_alu,
  output logic              busy,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              sel_md
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StHold, StForce} state_e;

  state_e              state_q, state_d;
  logic [REG_W-1:0]    buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                we_q, we_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sel_q, sel_d;

  logic alu_req;
  logic md_xfer;

  assign alu_req = alu_we && (alu_rd != '0);
  assign md_xfer = md_valid && (state_q == StIdle);

  assign md_ready  = (state_q == StIdle);
  assign stall_alu = (state_q == StForce);
  assign busy      = (state_q != StIdle);

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = reg_q;
  assign data_writeReg    = data_q;
  assign sel_md           = sel_q;

  always_comb begin
    state_d    = state_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = 1'b0;
    reg_d      = reg_q;
    data_d     = data_q;
    sel_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (md_xfer && !alu_req) begin
          // rd==0 results are accepted but never written
          we_d   = (md_rd != '0);
          reg_d  = md_rd;
          data_d = md_data;
          sel_d  = 1'b1;
        end else begin
          if (alu_req) begin
            we_d   = 1'b1;
            reg_d  = alu_rd;
            data_d = alu_data;
          end
          if (md_xfer && (md_rd != '0)) begin
            buf_rd_d   = md_rd;
            buf_data_d = md_data;
            wait_cnt_d = '0;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        if (!alu_req) begin
          we_d       = 1'b1;
          reg_d      = buf_rd_q;
          data_d     = buf_data_q;
          sel_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          we_d   = 1'b1;
          reg_d  = alu_rd;
          data_d = alu_data;
          if (alu_rd == buf_rd_q) begin
            // Younger ALU write to the same register supersedes the buffered result
            wait_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_d == CntW'(MAX_WAIT)) begin
              state_d = StForce;
            end
          end
        end
      end
      StForce: begin
        we_d       = 1'b1;
        reg_d      = buf_rd_q;
        data_d     = buf_data_q;
        sel_d      = 1'b1;
        wait_cnt_d = '0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned MAX_WAIT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              alu_we;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              md_valid;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic              stall_alu;
  logic              busy;
  logic              ctrl_writeEnable;
  logic [REG_W-1:0]  ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic              sel_md;

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_we          (alu_we),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .md_valid        (md_valid),
    .md_rd           (md_rd),
    .md_data         (md_data),
    .md_ready        (md_ready),
    .stall_alu       (stall_alu),
    .busy            (busy),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .sel_md          (sel_md)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic aw, input logic [REG_W-1:0] ard, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [REG_W-1:0] mrd, input logic [DATA_W-1:0] md);
    alu_we   = aw;
    alu_rd   = ard;
    alu_data = ad;
    md_valid = mv;
    md_rd    = mrd;
    md_data  = md;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] d, input logic sel);
    check({tag, ".we"}, ctrl_writeEnable, we);
    check({tag, ".reg"}, ctrl_writeReg, rd);
    check({tag, ".data"}, data_writeReg, d);
    check({tag, ".sel"}, sel_md, sel);
  endtask

  task automatic check_st(input string tag, input logic rdy, input logic stl, input logic bsy);
    check({tag, ".ready"}, md_ready, rdy);
    check({tag, ".stall"}, stall_alu, stl);
    check({tag, ".busy"}, busy, bsy);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    step();
    check_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_st("rst", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    // 1: plain ALU write
    drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
    step();
    check_wr("t1", 1'b1, 5'd3, 32'h11, 1'b0);

    // 2: md alone
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hAB);
    step();
    check_wr("t2", 1'b1, 5'd7, 32'hAB, 1'b1);
    check_st("t2", 1'b1, 1'b0, 1'b0);

    // 3: collision, buffer drains when ALU goes idle
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'hAB);
    step();
    check_wr("t3a", 1'b1, 5'd4, 32'h44, 1'b0);
    check_st("t3a", 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check_wr("t3b", 1'b1, 5'd7, 32'hAB, 1'b1);
    check_st("t3b", 1'b1, 1'b0, 1'b0);

    // 4: ALU keeps winning for MAX_WAIT cycles -> FORCE
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'hCD);
    step();
    drive(1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_wr("t4h", 1'b1, 5'd2, 32'h22, 1'b0);
      check_st("t4h", 1'b0, 1'b0, 1'b1);
    end
    step();
    check_wr("t4l", 1'b1, 5'd2, 32'h22, 1'b0);
    check_st("t4f", 1'b0, 1'b1, 1'b1);
    step();
    check_wr("t4b", 1'b1, 5'd7, 32'hCD, 1'b1);
    check_st("t4b", 1'b1, 1'b0, 1'b0);
    step();
    check_wr("t4r", 1'b1, 5'd2, 32'h22, 1'b0);

    // 5: WAW drops the buffered result
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77);
    step();
    drive(1'b1, 5'd7, 32'h55, 1'b0, '0, '0);
    step();
    check_wr("t5a", 1'b1, 5'd7, 32'h55, 1'b0);
    check_st("t5a", 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("t5b.we", ctrl_writeEnable, 1'b0);

    // 6: reset while holding discards the buffer
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
    step();
    check("t6a.busy", busy, 1'b1);
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check_wr("t6r", 1'b0, 5'd0, 32'h0, 1'b0);
    check_st("t6r", 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check("t6b.we", ctrl_writeEnable, 1'b0);
    check("t6b.busy", busy, 1'b0);

    // 7: null writes
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hEE);
    step();
    check("t7a.we", ctrl_writeEnable, 1'b0);
    check("t7a.busy", busy, 1'b0);
    drive(1'b1, 5'd0, 32'hEE, 1'b0, '0, '0);
    step();
    check("t7b.we", ctrl_writeEnable, 1'b0);
    drive(1'b1, 5'd5, 32'h5A, 1'b1, 5'd0, 32'hEE);
    step();
    check_wr("t7c", 1'b1, 5'd5, 32'h5A, 1'b0);
    check("t7c.busy", busy, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("t7d.we", ctrl_writeEnable, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
